pixel_sink: RTL

Receiving end of the drawer plot stream: accepts `plot`/`xCoord`/`yCoord`/`color` pixel writes from sprite and background drawers, buffers them in a small FIFO, and commits each pixel to the 320x240, 3-bit-per-pixel frame-buffer RAM write port. It also provides a full-screen clear sweep. It sits between the drawer FSMs and the frame-buffer memory that the VGA scanout reads.

---
 rtl/pixel_sink_pkg.sv | 35 +++
 rtl/pixel_sink_fifo.sv | 53 +++++
 rtl/pixel_sink.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pixel_sink_pkg.sv
// Shared types and constants for the pixel_sink frame-buffer write path.
package pixel_sink_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned PIXEL_W  = X_W + Y_W + COLOR_W;
    localparam int unsigned FB_LAST  = 76799;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRITE,
        CLEAR
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    // y*320 + x built from shifts, truncated to the RAM address width
    function automatic logic [ADDR_W-1:0] fb_addr(input pixel_t p);
        return (ADDR_W'(p.y) << 8) + (ADDR_W'(p.y) << 6) + ADDR_W'(p.x);
    endfunction

    function automatic logic in_range(input pixel_t p);
        return (p.x < X_W'(SCREEN_W)) && (p.y < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/pixel_sink_fifo.sv
// pixel_fifo: synchronous first-word-fall-through FIFO with registered full/empty flags.
module pixel_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr, wptr_nxt, rptr_nxt;
    logic             do_push, do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign wptr_nxt = wptr + PW'(do_push);
    assign rptr_nxt = rptr + PW'(do_pop);

    // Flags are computed from the next pointers so they change on the same edge as the push/pop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            full  <= (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
            empty <= (wptr_nxt == rptr_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    assign dout_c  = mem[rptr[AW-1:0]];
    assign level_c = wptr - rptr;

endmodule

// File: rtl/pixel_sink.sv
// pixel_sink: buffers drawer pixel writes and commits them, or a full-screen clear, to the frame buffer.
// Optional macro PIXEL_SINK_CLIP_EN discards off-screen pixels at pop instead of aliasing them.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int unsigned        FIFO_DEPTH  = 8,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               plot,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               clear,
    output logic               full,
    output logic               busy,
    output logic               overflow,
    output logic               clear_done,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ready
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    state_t             state_q, state_d;
    pixel_t             pix_q, pix_d;
    pixel_t             plot_pix, fifo_dout_c;
    logic [LW-1:0]      fifo_level_c;
    logic               fifo_empty, fifo_pop, fifo_nonempty_nxt;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [COLOR_W-1:0] mem_data_d;
    logic               mem_we_d, clear_pending_q, clear_pending_d;
    logic               clear_done_d, overflow_d, busy_d;

    assign plot_pix = '{x: x_in, y: y_in, color: color_in};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (plot),
        .din     (plot_pix),
        .pop     (fifo_pop),
        .dout_c  (fifo_dout_c),
        .full    (full),
        .empty   (fifo_empty),
        .level_c (fifo_level_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            pix_q           <= '0;
            clr_cnt_q       <= '0;
            clear_pending_q <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_data        <= '0;
            clear_done      <= 1'b0;
            overflow        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            pix_q           <= pix_d;
            clr_cnt_q       <= clr_cnt_d;
            clear_pending_q <= clear_pending_d;
            mem_we          <= mem_we_d;
            mem_addr        <= mem_addr_d;
            mem_data        <= mem_data_d;
            clear_done      <= clear_done_d;
            overflow        <= overflow_d;
            busy            <= busy_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pix_d           = pix_q;
        clr_cnt_d       = clr_cnt_q;
        mem_we_d        = mem_we;
        mem_addr_d      = mem_addr;
        mem_data_d      = mem_data;
        clear_done_d    = 1'b0;
        fifo_pop        = 1'b0;
        overflow_d      = overflow || (plot && full);
        clear_pending_d = clear_pending_q || (clear && (state_q != CLEAR));

        case (state_q)
            IDLE: begin
                if (clear_pending_q) begin
                    state_d         = CLEAR;
                    clear_pending_d = 1'b0;
                    clr_cnt_d       = '0;
                    mem_we_d        = 1'b1;
                    mem_addr_d      = '0;
                    mem_data_d      = CLEAR_COLOR;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
`ifdef PIXEL_SINK_CLIP_EN
                    if (in_range(fifo_dout_c)) begin
                        pix_d   = fifo_dout_c;
                        state_d = CALC;
                    end
`else
                    pix_d   = fifo_dout_c;
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                mem_addr_d = fb_addr(pix_q);
                mem_data_d = pix_q.color;
                mem_we_d   = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                if (mem_ready) begin
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            CLEAR: begin
                if (mem_ready) begin
                    if (clr_cnt_q == ADDR_W'(FB_LAST)) begin
                        mem_we_d     = 1'b0;
                        clear_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
                        mem_addr_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // busy tracks the post-edge occupancy so it rises with the accepting edge
        fifo_nonempty_nxt = (plot && !full) ||
                            ((fifo_level_c != '0) && !(fifo_pop && (fifo_level_c == LW'(1))));
        busy_d = (state_d != IDLE) || clear_pending_d || fifo_nonempty_nxt;
    end

endmodule
